// File: rtl/score_ram_arbiter_pkg.sv
// Shared widths, FSM encoding and arbitration flag for the
// scoreboard RAM arbiter.
package score_ram_arbiter_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;
  localparam int SCORE_MAX  = 2**DEF_DATA_W - 1;

  typedef enum logic [3:0] {
    S_CLR,
    S_IDLE,
    S_U_RD,
    S_U_W1,
    S_U_W2,
    S_U_WR,
    S_D_RD,
    S_D_W1,
    S_D_W2,
    S_D_DONE
  } state_t;

  typedef enum logic {
    RR_UPD,
    RR_DISP
  } rr_t;

endpackage

// File: rtl/score_ram_arbiter_sat_add.sv
// Combinational saturating adder: the sum is formed one bit
// wider and clamps to all-ones on carry out.
module score_sat_add #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];

endmodule

// File: rtl/score_ram_arbiter.sv
// Single owner of the scoreboard RAM port: clears it, runs
// saturating score updates and serves display reads.
module score_ram_arbiter
  import score_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_id,
  input  logic [DATA_W-1:0] upd_pts,
  output logic              upd_ack,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_id,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_score,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int NUM_SLOTS = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = NUM_SLOTS[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_IDX = (ADDR_W+1)'(1);

  state_t            r_state;
  rr_t               r_rr_last;
  logic [ADDR_W:0]   r_clr_idx;
  logic              r_clr_pend;
  logic [DATA_W-1:0] r_pts;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_wren;
  logic              r_upd_ack;
  logic              r_disp_ack;
  logic [DATA_W-1:0] r_disp_score;
  logic              r_busy;

  logic              w_grant_upd;
  logic              w_grant_disp;
  logic [DATA_W-1:0] w_new_score;

  assign w_grant_upd  = upd_req &&
                        (!disp_req || r_rr_last == RR_DISP);
  assign w_grant_disp = disp_req && !w_grant_upd;

  score_sat_add #(
    .DATA_W (DATA_W)
  ) u_sat_add (
    .i_a   (ram_q),
    .i_b   (r_pts),
    .o_sum (w_new_score)
  );

  // Outputs are registered on entry, so each state's RAM
  // controls are loaded by the edge that enters it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_CLR;
      r_rr_last    <= RR_DISP;
      r_clr_idx    <= '0;
      r_clr_pend   <= 1'b0;
      r_pts        <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_wren   <= 1'b0;
      r_upd_ack    <= 1'b0;
      r_disp_ack   <= 1'b0;
      r_disp_score <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_upd_ack   <= 1'b0;
      r_disp_ack  <= 1'b0;
      r_ram_wren  <= 1'b0;
      r_ram_wdata <= '0;
      if (clr_req && r_state != S_IDLE)
        r_clr_pend <= 1'b1;
      unique case (r_state)
        S_CLR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_ram_addr <= '0;
            r_clr_idx  <= '0;
          end else begin
            r_busy     <= 1'b1;
            r_ram_wren <= 1'b1;
            r_ram_addr <= r_clr_idx[ADDR_W-1:0];
            r_clr_idx  <= r_clr_idx + ONE_IDX;
          end
        end
        S_IDLE: begin
          if (clr_req || r_clr_pend) begin
            r_clr_pend <= 1'b0;
            r_state    <= S_CLR;
            r_busy     <= 1'b1;
            r_ram_wren <= 1'b1;
            r_ram_addr <= '0;
            r_clr_idx  <= ONE_IDX;
          end else if (w_grant_upd) begin
            r_state    <= S_U_RD;
            r_busy     <= 1'b1;
            r_ram_addr <= upd_id;
            r_pts      <= upd_pts;
            r_rr_last  <= RR_UPD;
          end else if (w_grant_disp) begin
            r_state    <= S_D_RD;
            r_busy     <= 1'b1;
            r_ram_addr <= disp_id;
            r_rr_last  <= RR_DISP;
          end
        end
        S_U_RD: r_state <= S_U_W1;
        S_U_W1: r_state <= S_U_W2;
        S_U_W2: begin
          r_state     <= S_U_WR;
          r_ram_wren  <= 1'b1;
          r_ram_wdata <= w_new_score;
          r_upd_ack   <= 1'b1;
        end
        S_U_WR: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_ram_addr <= '0;
        end
        S_D_RD: r_state <= S_D_W1;
        S_D_W1: r_state <= S_D_W2;
        S_D_W2: begin
          r_state      <= S_D_DONE;
          r_disp_score <= ram_q;
          r_disp_ack   <= 1'b1;
        end
        S_D_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_ram_addr <= '0;
        end
        default: begin
          r_state   <= S_CLR;
          r_clr_idx <= '0;
        end
      endcase
    end
  end

  assign upd_ack    = r_upd_ack;
  assign disp_ack   = r_disp_ack;
  assign disp_score = r_disp_score;
  assign busy       = r_busy;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_wren   = r_ram_wren;

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Directed bench for score_ram_arbiter with a registered
// addr/q RAM model attached to its port.
module tb_score_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       upd_req;
  logic [1:0] upd_id;
  logic [3:0] upd_pts;
  logic       upd_ack;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       disp_ack;
  logic [3:0] disp_score;
  logic       clr_req;
  logic       busy;
  logic [1:0] ram_addr;
  logic [3:0] ram_wdata;
  logic       ram_wren;
  logic [3:0] ram_q;

  logic [3:0] mem [4];
  logic [1:0] r_a;

  int passes;
  int checks;
  int seq [4];
  int val [4];

  score_ram_arbiter #(
    .ADDR_W (2),
    .DATA_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_req    (upd_req),
    .upd_id     (upd_id),
    .upd_pts    (upd_pts),
    .upd_ack    (upd_ack),
    .disp_req   (disp_req),
    .disp_id    (disp_id),
    .disp_ack   (disp_ack),
    .disp_score (disp_score),
    .clr_req    (clr_req),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren)
      mem[ram_addr] <= ram_wdata;
    r_a   <= ram_addr;
    ram_q <= mem[r_a];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic do_upd(input logic [1:0] id,
                        input logic [3:0] pts,
                        input logic [3:0] exp_w);
    int n;
    int wr;
    bit got;
    upd_id  = id;
    upd_pts = pts;
    upd_req = 1'b1;
    n = 0;
    wr = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (ram_wren) wr++;
      if (upd_ack) got = 1'b1;
    end
    check("upd_lat", n, 4);
    check("upd_addr", ram_addr, id);
    check("upd_wdata", ram_wdata, exp_w);
    check("upd_wren_cnt", wr, 1);
    upd_req = 1'b0;
    tick();
    check("upd_busy_end", busy, 0);
  endtask

  task automatic do_disp(input logic [1:0] id,
                         input logic [3:0] exp_s);
    int n;
    bit got;
    disp_id  = id;
    disp_req = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (ram_wren) check("disp_no_wren", ram_wren, 0);
      if (disp_ack) got = 1'b1;
    end
    check("disp_lat", n, 4);
    check("disp_score", disp_score, exp_s);
    disp_req = 1'b0;
    tick();
    check("disp_busy_end", busy, 0);
    check("disp_hold", disp_score, exp_s);
  endtask

  task automatic check_clear();
    for (int i = 1; i < 4; i++) begin
      tick();
      check("clr_wren", ram_wren, 1);
      check("clr_addr", ram_addr, i);
      check("clr_wdata", ram_wdata, 0);
    end
    tick();
    check("clr_done_busy", busy, 0);
    check("clr_done_wren", ram_wren, 0);
  endtask

  initial begin
    int ev;
    int n;
    passes   = 0;
    checks   = 0;
    rst      = 1'b0;
    upd_req  = 1'b0;
    upd_id   = '0;
    upd_pts  = '0;
    disp_req = 1'b0;
    disp_id  = '0;
    clr_req  = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_ack", upd_ack, 0);
    check("rst_score", disp_score, 0);
    #2 rst = 1'b1;

    tick();
    check("init_wren0", ram_wren, 1);
    check("init_addr0", ram_addr, 0);
    check("init_busy", busy, 1);
    check_clear();

    do_upd(2'd2, 4'd5, 4'd5);
    do_upd(2'd2, 4'd3, 4'd8);
    do_upd(2'd1, 4'd12, 4'd12);
    do_upd(2'd1, 4'd9, 4'd15);
    do_disp(2'd2, 4'd8);
    do_disp(2'd1, 4'd15);

    upd_id   = 2'd3;
    upd_pts  = 4'd1;
    disp_id  = 2'd3;
    upd_req  = 1'b1;
    disp_req = 1'b1;
    ev = 0;
    n  = 0;
    while (ev < 4 && n < 60) begin
      tick();
      n++;
      if (upd_ack) begin
        seq[ev] = 0;
        val[ev] = int'(ram_wdata);
        ev++;
      end else if (disp_ack) begin
        seq[ev] = 1;
        val[ev] = int'(disp_score);
        ev++;
      end
      if (ev == 4) begin
        upd_req  = 1'b0;
        disp_req = 1'b0;
      end
    end
    upd_req  = 1'b0;
    disp_req = 1'b0;
    check("rr_events", ev, 4);
    for (int i = 0; i < ev; i++) begin
      check("rr_order", seq[i], i % 2);
      check("rr_value", val[i], (i / 2) + 1);
    end
    tick();
    check("rr_busy_end", busy, 0);

    do_upd(2'd0, 4'd4, 4'd4);
    do_disp(2'd0, 4'd4);

    upd_id  = 2'd0;
    upd_pts = 4'd1;
    upd_req = 1'b1;
    tick();
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clrmid_noack", upd_ack, 0);
    tick();
    check("clrmid_ack", upd_ack, 1);
    check("clrmid_wdata", ram_wdata, 5);
    upd_req = 1'b0;
    tick();
    check("clrmid_idle", busy, 0);
    tick();
    check("clrmid_wren0", ram_wren, 1);
    check("clrmid_addr0", ram_addr, 0);
    check_clear();
    do_disp(2'd0, 4'd0);
    do_disp(2'd2, 4'd0);

    upd_id  = 2'd1;
    upd_pts = 4'd7;
    upd_req = 1'b1;
    repeat (4) tick();
    rst     = 1'b0;
    upd_req = 1'b0;
    #1;
    check("rstwr_wren", ram_wren, 0);
    check("rstwr_ack", upd_ack, 0);
    check("rstwr_busy", busy, 0);
    #2 rst = 1'b1;
    tick();
    check("rstwr_addr0", ram_addr, 0);
    check("rstwr_wren0", ram_wren, 1);
    check("rstwr_noack", upd_ack, 0);
    check_clear();
    do_disp(2'd1, 4'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
